// File: rtl/iter_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : iter_muldiv
// Description : Iterative RISC-V M-extension multiply/divide unit. One
//               operation at a time, XLEN iterations per operation, with a
//               constant latency of XLEN+1 cycles from the accepting edge to
//               the done pulse for every op and every operand value.
//               Multiply is radix-2 shift-add on operand magnitudes; divide is
//               restoring shift-subtract on magnitudes; sign is fixed up when
//               the result is registered.
// Build macro : ITER_MULDIV_DIV_EN - when defined, the divider is compiled in
//               and all eight ops are legal. When undefined, ops 100-111 run
//               the same state sequence but return result=0 with illegal=1.
// Ports       : clk     - clock, rising edge
//               reset   - asynchronous active-high reset
//               start   - operation request (ignored while busy)
//               op      - func3: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//               a, b    - operands rs1, rs2
//               busy    - iteration in progress
//               done    - one-cycle result-valid pulse
//               result  - registered result, held until next done or reset
//               illegal - op unsupported in this build (valid with done)
// Revision    : 1.0 - initial release
// ============================================================================
module iter_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int          c_CW   = $clog2(XLEN);
  localparam logic [1:0]  c_IDLE = 2'd0;
  localparam logic [1:0]  c_CALC = 2'd1;
  localparam logic [1:0]  c_DONE = 2'd2;
  localparam logic [XLEN-1:0]   c_ONE  = XLEN'(1);
  localparam logic [2*XLEN-1:0] c_ONE2 = (2*XLEN)'(1);

  logic [1:0]        r_state, w_next_state;
  logic [c_CW-1:0]   r_count;
  logic [2*XLEN-1:0] r_acc, w_acc_next;
  logic [XLEN-1:0]   r_opnd;
  logic [2:0]        r_op;
  logic              r_neg_res;
  logic [XLEN-1:0]   r_result, w_final;
  logic              r_illegal, w_illegal_op;
  logic              w_accept, w_last;
  logic              w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_mul_next, w_prod;
  logic [XLEN-1:0]   w_mul_res;

`ifdef ITER_MULDIV_DIV_EN
  logic              r_neg_rem, r_div_zero;
  logic [XLEN-1:0]   r_a;
  logic [XLEN:0]     w_rem_sh, w_trial;
  logic              w_ge;
  logic [2*XLEN-1:0] w_div_next;
  logic [XLEN-1:0]   w_quo, w_rem, w_quo_fix, w_rem_fix;
`endif

  assign w_accept = start && ((r_state == c_IDLE) || (r_state == c_DONE));
  assign w_last   = (r_state == c_CALC) && (r_count == '0);

  // Operand signedness by func3. MUL treats both as signed: the low half of
  // the product is the same either way.
  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    if (op[2]) begin
      w_a_signed = ~op[0];
      w_b_signed = ~op[0];
    end else begin
      w_a_signed = (op[1:0] != 2'b11);
      w_b_signed = ~op[1];
    end
  end

  assign w_a_neg = w_a_signed & a[XLEN-1];
  assign w_b_neg = w_b_signed & b[XLEN-1];
  assign w_a_mag = w_a_neg ? (~a + c_ONE) : a;
  assign w_b_mag = w_b_neg ? (~b + c_ONE) : b;

  // Shift-add step: acc = {partial high, remaining multiplier bits}.
  assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_sum, r_acc[XLEN-1:1]};

`ifdef ITER_MULDIV_DIV_EN
  // Restoring step: acc = {partial remainder, dividend/quotient bits}.
  // Bit XLEN of the trial difference is the borrow.
  assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
  assign w_trial    = w_rem_sh - {1'b0, r_opnd};
  assign w_ge       = ~w_trial[XLEN];
  assign w_div_next = {(w_ge ? w_trial[XLEN-1:0] : w_rem_sh[XLEN-1:0]),
                       r_acc[XLEN-2:0], w_ge};
  assign w_acc_next = r_op[2] ? w_div_next : w_mul_next;
`else
  assign w_acc_next = w_mul_next;
`endif

  // Final result is formed from the last iteration's value so it can be
  // registered on the CALC->DONE edge itself.
  assign w_prod    = r_neg_res ? (~w_acc_next + c_ONE2) : w_acc_next;
  assign w_mul_res = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

`ifdef ITER_MULDIV_DIV_EN
  // Divide by zero falls out of the iteration as quotient all-ones and
  // remainder |a|; the raw values are forced so sign fix-up cannot alter them.
  // Signed overflow needs no special case: |a|/1 negated twice returns a.
  assign w_quo     = w_acc_next[XLEN-1:0];
  assign w_rem     = w_acc_next[2*XLEN-1:XLEN];
  assign w_quo_fix = r_div_zero ? '1  : (r_neg_res ? (~w_quo + c_ONE) : w_quo);
  assign w_rem_fix = r_div_zero ? r_a : (r_neg_rem ? (~w_rem + c_ONE) : w_rem);
  assign w_final      = r_op[2] ? (r_op[1] ? w_rem_fix : w_quo_fix) : w_mul_res;
  assign w_illegal_op = 1'b0;
`else
  assign w_final      = r_op[2] ? '0 : w_mul_res;
  assign w_illegal_op = r_op[2];
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = c_IDLE;
    case (r_state)
      c_IDLE, c_DONE: w_next_state = start ? c_CALC : c_IDLE;
      c_CALC:         w_next_state = (r_count == '0) ? c_DONE : c_CALC;
      default:        w_next_state = c_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy    = (r_state == c_CALC);
    done    = (r_state == c_DONE);
    illegal = (r_state == c_DONE) & r_illegal;
    result  = r_result;
  end

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count    <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_op       <= '0;
      r_neg_res  <= 1'b0;
      r_result   <= '0;
      r_illegal  <= 1'b0;
`ifdef ITER_MULDIV_DIV_EN
      r_neg_rem  <= 1'b0;
      r_div_zero <= 1'b0;
      r_a        <= '0;
`endif
    end else if (w_accept) begin
      r_op      <= op;
      r_count   <= c_CW'(XLEN-1);
      r_neg_res <= w_a_neg ^ w_b_neg;
`ifdef ITER_MULDIV_DIV_EN
      r_neg_rem  <= w_a_neg;
      r_div_zero <= (b == '0);
      r_a        <= a;
      if (op[2]) begin
        r_acc  <= {{XLEN{1'b0}}, w_a_mag};
        r_opnd <= w_b_mag;
      end else begin
        r_acc  <= {{XLEN{1'b0}}, w_b_mag};
        r_opnd <= w_a_mag;
      end
`else
      r_acc  <= {{XLEN{1'b0}}, w_b_mag};
      r_opnd <= w_a_mag;
`endif
    end else if (r_state == c_CALC) begin
      r_acc   <= w_acc_next;
      r_count <= r_count - c_CW'(1);
      if (w_last) begin
        r_result  <= w_final;
        r_illegal <= w_illegal_op;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iter_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_iter_muldiv
// Description : Self-checking bench for iter_muldiv (XLEN=32). An arithmetic
//               reference model predicts busy/done/illegal/result each cycle;
//               directed vectors also carry hand-computed expected values.
//               Honours ITER_MULDIV_DIV_EN for the divide expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_muldiv;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a, b;
  logic            busy, done, illegal;
  logic [XLEN-1:0] result;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

`ifdef ITER_MULDIV_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  iter_muldiv #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: {illegal, result} from plain integer arithmetic.
  function automatic logic [32:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy, p;
    logic [63:0] t;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    if (o[2] && !DIV_ON) return {1'b1, 32'h0};
    case (o)
      3'd0: begin p = sx * sy; t = p; return {1'b0, t[31:0]}; end
      3'd1: begin p = sx * sy; t = p; return {1'b0, t[63:32]}; end
      3'd2: begin p = sx * uy; t = p; return {1'b0, t[63:32]}; end
      3'd3: begin t = {32'b0, x} * {32'b0, y}; return {1'b0, t[63:32]}; end
      3'd4: begin if (y == 0) return {1'b0, 32'hFFFFFFFF}; p = sx / sy; t = p; return {1'b0, t[31:0]}; end
      3'd5: begin if (y == 0) return {1'b0, 32'hFFFFFFFF}; p = ux / uy; t = p; return {1'b0, t[31:0]}; end
      3'd6: begin if (y == 0) return {1'b0, x}; p = sx % sy; t = p; return {1'b0, t[31:0]}; end
      default: begin if (y == 0) return {1'b0, x}; p = ux % uy; t = p; return {1'b0, t[31:0]}; end
    endcase
  endfunction

  // Timeline model: an accepted request keeps the unit busy for XLEN cycles,
  // then result/illegal appear with a one-cycle done.
  int              m_left;
  logic            m_done, m_ill, m_pill;
  logic [XLEN-1:0] m_result, m_pres;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left <= 0; m_done <= 1'b0; m_ill <= 1'b0; m_pill <= 1'b0;
      m_result <= '0; m_pres <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1; m_result <= m_pres; m_ill <= m_pill;
        end
      end else if (start) begin
        m_left <= XLEN;
        {m_pill, m_pres} <= model(op, a, b);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc busy", 64'(busy), 64'(m_left != 0));
      chk("cyc done", 64'(done), 64'(m_done));
      chk("cyc result", 64'(result), 64'(m_result));
      chk("cyc illegal", 64'(illegal), 64'(m_done & m_ill));
    end
  end

  task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_op(input string nm, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] er, input bit ei);
    int cyc, bcnt;
    launch(o, x, y);
    cyc = 0; bcnt = 0;
    do begin
      @(negedge clk); cyc++;
      if (busy) bcnt++;
    end while (!done && cyc < 100);
    chk({nm, " latency"}, 64'(cyc), 64'd33);
    chk({nm, " busy cycles"}, 64'(bcnt), 64'd32);
    chk({nm, " result"}, 64'(result), 64'(er));
    chk({nm, " illegal"}, 64'(illegal), 64'(ei));
  endtask

  task automatic do_model_op(input string nm, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [32:0] e;
    e = model(o, x, y);
    do_op(nm, o, x, y, e[31:0], e[32]);
  endtask

  initial begin
    int cyc, dcnt;
    logic [31:0] vec_a [6] = '{32'h0, 32'h1, 32'h12345678, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    logic [31:0] vec_b [6] = '{32'h5, 32'hFFFFFFFF, 32'h00000100, 32'h7, 32'h3, 32'h80000000};

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    chk("reset illegal", 64'(illegal), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk_en = 1'b1;

    do_op("mul 7*-3", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
    do_op("mulh min*min", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
    do_op("mulhu max*max", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    do_op("mulhsu -1*max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);

    do_op("div -7/2", 3'd4, 32'hFFFFFFF9, 32'd2, DIV_ON ? 32'hFFFFFFFD : 32'h0, !DIV_ON);
    do_op("rem -7/2", 3'd6, 32'hFFFFFFF9, 32'd2, DIV_ON ? 32'hFFFFFFFF : 32'h0, !DIV_ON);
    do_op("divu 5/0", 3'd5, 32'd5, 32'd0, DIV_ON ? 32'hFFFFFFFF : 32'h0, !DIV_ON);
    do_op("remu 5/0", 3'd7, 32'd5, 32'd0, DIV_ON ? 32'd5 : 32'h0, !DIV_ON);
    do_op("div ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, DIV_ON ? 32'h80000000 : 32'h0, !DIV_ON);
    do_op("rem ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, !DIV_ON);
    do_op("divu 9/3", 3'd5, 32'd9, 32'd3, DIV_ON ? 32'd3 : 32'h0, !DIV_ON);
    do_op("mul 3*3", 3'd0, 32'd3, 32'd3, 32'd9, 1'b0);

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 8; k++) begin
        do_model_op($sformatf("op%0d vec%0d", k, i), 3'(k), vec_a[i], vec_b[i]);
      end
    end

    // Back-to-back: second request accepted in DONE, old result held.
    do_op("b2b first", 3'd0, 32'd5, 32'd6, 32'd30, 1'b0);
    start = 1'b1; op = 3'd3; a = 32'hFFFFFFFF; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    @(negedge clk);
    chk("b2b busy at once", 64'(busy), 64'd1);
    chk("b2b old result", 64'(result), 64'd30);
    repeat (20) @(negedge clk);
    cyc += 20;
    chk("b2b held mid-calc", 64'(result), 64'd30);
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    chk("b2b latency", 64'(cyc), 64'd33);
    chk("b2b result", 64'(result), 64'd1);

    // Start pulsed mid-calc must be ignored.
    launch(3'd0, 32'd100, 32'd3);
    cyc = 0;
    do begin
      @(negedge clk); cyc++;
      if (cyc == 5) begin start = 1'b1; op = 3'd0; a = 32'd1; b = 32'd1; end
      if (cyc == 6) start = 1'b0;
    end while (!done && cyc < 100);
    chk("glitch latency", 64'(cyc), 64'd33);
    chk("glitch result", 64'(result), 64'd300);

    // Reset 10 cycles into CALC aborts without a done.
    launch(3'd0, 32'd2, 32'd2);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort result", 64'(result), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    dcnt = 0;
    repeat (40) begin @(negedge clk); if (done) dcnt++; end
    chk("abort no done", 64'(dcnt), 64'd0);
    chk("abort idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iter_muldiv.md
ITER_MULDIV -- requirements
Module: iter_muldiv

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning operand and result width; legal values are 8, 16, 32 and 64.
REQ-002 The block SHALL have port clk, input, 1 bit: clock, with all state updated on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit: operation request.
REQ-005 The block SHALL have port op, input, 3 bits: RV M-extension func3.
- 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
- 100 DIV, 101 DIVU, 110 REM, 111 REMU
REQ-006 The block SHALL have ports a and b, input, XLEN bits each: operand a (rs1) and operand b (rs2).
REQ-007 The block SHALL have port busy, output, 1 bit: iteration in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle result-valid pulse.
REQ-009 The block SHALL have port result, output, XLEN bits: the final result.
REQ-010 The block SHALL have port illegal, output, 1 bit: the operation is not supported in this build, valid while done is 1.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-012 In IDLE or DONE, start=1 at a rising edge SHALL accept the request: capture op, a and b; enter CALC; load the iteration counter with XLEN-1.
REQ-013 In IDLE or DONE with start=0, the FSM SHALL go to IDLE on the next edge (DONE lasts exactly one cycle).
REQ-014 While in CALC, start SHALL be ignored and busy SHALL be 1; busy SHALL be 0 in all other states.
REQ-015 CALC SHALL last exactly XLEN cycles, one iteration per cycle, then enter DONE.
- Multiply: radix-2 shift-add on operand magnitudes, 2*XLEN-bit product.
- Divide: restoring shift-subtract on magnitudes.
REQ-016 done SHALL be 1 only in DONE, i.e. XLEN+1 cycles after the accepting edge; latency SHALL be constant for every op and operand value.
REQ-017 result SHALL be registered on CALC->DONE with sign correction applied, and held unchanged until the next DONE or reset.
REQ-018 Result selection SHALL be:
- MUL: low XLEN bits of the product.
- MULH: high half, signed x signed.
- MULHSU: high half, a signed x b unsigned.
- MULHU: high half, unsigned x unsigned.
- Quotient sign: sign(a) XOR sign(b). Remainder sign: sign(a).
REQ-019 Divide by zero SHALL produce: DIV/DIVU quotient = all ones; REM/REMU = a.
REQ-020 Signed overflow (a = most-negative, b = -1) SHALL produce: DIV = a; REM = 0.
REQ-021 Special cases SHALL still take the full XLEN+1-cycle latency.
REQ-022 A start accepted in DONE (back-to-back) SHALL produce no idle cycle; the previous result SHALL remain on result throughout the new CALC.

Reset
REQ-023 Asserting reset SHALL force:
- state IDLE
- busy=0, done=0, illegal=0
- result=0
- counter and internal accumulators cleared
REQ-024 Reset asserted during CALC SHALL abort the operation; no done pulse SHALL follow for the aborted request.

Configuration
REQ-025 The divide datapath SHALL be compiled in only when macro ITER_MULDIV_DIV_EN is defined.
REQ-026 With ITER_MULDIV_DIV_EN defined, all eight ops SHALL be supported and illegal SHALL always be 0.
REQ-027 Without ITER_MULDIV_DIV_EN, ops 100-111 SHALL still be accepted and follow the same state sequence and latency, with result=0 and illegal=1 in DONE; no divider logic SHALL be synthesised.

Verification (XLEN=32)
REQ-028 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done high exactly 33 cycles after the accepting edge, busy high for 32 cycles.
REQ-029 MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=b=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-030 Signed divide a=0xFFFFFFF9 (-7), b=2 -> DIV 0xFFFFFFFD; REM 0xFFFFFFFF.
REQ-031 Divide special cases:
- DIVU a=5, b=0 -> 0xFFFFFFFF; REMU a=5, b=0 -> 5.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
REQ-032 Start pulsed during CALC -> ignored, result from the original operands; reset asserted 10 cycles into CALC -> busy=0, result=0, no done pulse.
REQ-033 Build without ITER_MULDIV_DIV_EN, DIVU 9/3 -> done at cycle 33 with result 0 and illegal=1; a following MUL 3*3 -> result 9 with illegal=0.
